dmem_arbiter: RTL



---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/burst_addr_gen.sv | 42 ++++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_EXT  = 1'b1
   } arb_state_e;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 4;

endpackage

// File: rtl/burst_addr_gen.sv
// Latches a burst's base and length at grant and steps the beat counter,
// giving the address of the current beat and whether it is the last one.
module burst_addr_gen #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base_in,
   input  logic [LEN_W-1:0]  len_in,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [ADDR_W-1:0] base_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  next_cnt;

   assign next_cnt = cnt_q + LEN_W'(1);
   // Address arithmetic wraps modulo 2^ADDR_W.
   assign addr     = base_q + ADDR_W'(cnt_q);
   assign last     = (cnt_q == len_q);

   // Beat 0 goes out from the live request, so the counter starts at 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         base_q <= base_in;
         len_q  <= len_in;
         cnt_q  <= LEN_W'(1);
      end else if (advance) begin
         cnt_q  <= next_cnt;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory shared by the CPU (priority) and an external burst
// port with bounded wait. dbg_state exposes the FSM state.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int LEN_W    = LEN_W_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_r,
   input  logic              cpu_w,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [LEN_W-1:0]  ext_len,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_beat,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_rvalid,
   output logic              ext_done,
   output logic              mem_r,
   output logic              mem_w,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output arb_state_e        dbg_state
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   arb_state_e        state, next_state;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              we_q;
   logic              cpu_rvalid_q, ext_rvalid_q;
   logic              cpu_rd_go, ext_rd_go;
   logic              load, advance;
   logic              cpu_acc, ext_prio;
   logic [ADDR_W-1:0] gen_addr;
   logic              gen_last;

   burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_gen (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .advance (advance),
      .base_in (ext_addr),
      .len_in  (ext_len),
      .addr    (gen_addr),
      .last    (gen_last)
   );

   assign cpu_acc    = cpu_r | cpu_w;
   assign ext_prio   = ext_req && (wait_cnt == WAIT_W'(MAX_WAIT));
   assign cpu_rdata  = mem_rdata;
   assign ext_rdata  = mem_rdata;
   assign cpu_rvalid = cpu_rvalid_q;
   assign ext_rvalid = ext_rvalid_q;
   assign dbg_state  = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ARB_IDLE;
         wait_cnt     <= '0;
         we_q         <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         ext_rvalid_q <= 1'b0;
      end else begin
         state        <= next_state;
         wait_cnt     <= wait_nxt;
         cpu_rvalid_q <= cpu_rd_go;
         ext_rvalid_q <= ext_rd_go;
         if (load) we_q <= ext_we;
      end
   end

   // Outputs are gated by reset so nothing reaches memory while it is held.
   always_comb begin
      next_state = state;
      wait_nxt   = wait_cnt;
      load       = 1'b0;
      advance    = 1'b0;
      cpu_stall  = 1'b0;
      ext_gnt    = 1'b0;
      ext_beat   = 1'b0;
      ext_done   = 1'b0;
      mem_r      = 1'b0;
      mem_w      = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      cpu_rd_go  = 1'b0;
      ext_rd_go  = 1'b0;
      if (reset) begin
         case (state)
            ARB_IDLE: begin
               if (cpu_acc && !ext_prio) begin
                  mem_w     = cpu_w;
                  mem_r     = cpu_r & ~cpu_w;
                  mem_addr  = cpu_addr;
                  mem_wdata = cpu_wdata;
                  cpu_rd_go = cpu_r & ~cpu_w;
                  if (!ext_req) wait_nxt = '0;
                  else if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_nxt = wait_cnt + WAIT_W'(1);
               end else if (ext_req) begin
                  ext_gnt   = 1'b1;
                  ext_beat  = 1'b1;
                  mem_w     = ext_we;
                  mem_r     = ~ext_we;
                  mem_addr  = ext_addr;
                  mem_wdata = ext_wdata;
                  ext_rd_go = ~ext_we;
                  cpu_stall = cpu_acc;
                  load      = 1'b1;
                  wait_nxt  = '0;
                  if (ext_len == '0) ext_done = 1'b1;
                  else next_state = ARB_EXT;
               end else begin
                  wait_nxt = '0;
               end
            end
            ARB_EXT: begin
               ext_beat  = 1'b1;
               mem_w     = we_q;
               mem_r     = ~we_q;
               mem_addr  = gen_addr;
               mem_wdata = ext_wdata;
               ext_rd_go = ~we_q;
               cpu_stall = cpu_acc;
               if (gen_last) begin
                  ext_done   = 1'b1;
                  next_state = ARB_IDLE;
               end else begin
                  advance = 1'b1;
               end
            end
            default: next_state = ARB_IDLE;
         endcase
      end
   end

endmodule
